// File: rtl/mul_seq_pkg.sv
// Shared constants and types for the multi-cycle multiply sequencer.
package mul_seq_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Request attributes captured alongside the operands when start is taken
  typedef struct packed {
    logic       accumulate;
    logic       set_flags;
    logic [3:0] dest;
  } req_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: one multiplier bit per step, optional accumulate.
module mul_shift_add_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             add_acc,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] mcand, mplier, acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc_q   <= '0;
      product <= '0;
    end else if (load) begin
      mcand   <= op_a;
      mplier  <= op_b;
      acc_q   <= acc;
      product <= '0;
    end else if (step) begin
      // Carries past WIDTH bits fall off; only the low half is kept
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end else if (add_acc) begin
      product <= product + acc_q;
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// MUL/MLA sequencer: FSM and iteration counter around the shift-add datapath.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             accumulate,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       dest,
  input  logic             flush,
  output logic             busy,
  output logic             freeze,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       result_dest,
  output logic             flags_we,
  output logic [1:0]       flags_nz
);

  localparam int CW = cnt_w(WIDTH);

  logic [1:0]       state, state_nx;
  logic [CW-1:0]    count;
  req_t             req_q;
  logic [WIDTH-1:0] product, result_q;
  logic [3:0]       dest_q;
  logic [1:0]       nz_q, nz;
  logic             take, last;

  assign take = (state == ST_IDLE) && start && !flush;
  assign last = (count == CW'(1));
  assign nz   = {product[WIDTH-1], product == '0};

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (take) state_nx = ST_MUL;
      ST_MUL:  if (last) state_nx = req_q.accumulate ? ST_ACC : ST_DONE;
      ST_ACC:  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (flush) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      req_q    <= '0;
      result_q <= '0;
      dest_q   <= '0;
      nz_q     <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        count <= CW'(WIDTH);
        req_q <= '{accumulate: accumulate, set_flags: set_flags, dest: dest};
      end else if (state == ST_MUL) begin
        count <= count - CW'(1);
      end
      // Hold copies keep the outputs stable once the next request clears product
      if (done) begin
        result_q <= product;
        dest_q   <= req_q.dest;
        nz_q     <= nz;
      end
    end
  end

  mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (take),
    .step    (state == ST_MUL),
    .add_acc (state == ST_ACC),
    .op_a    (op_a),
    .op_b    (op_b),
    .acc     (acc),
    .product (product)
  );

  assign busy        = (state != ST_IDLE);
  assign freeze      = take || (state == ST_MUL) || (state == ST_ACC);
  assign done        = (state == ST_DONE) && !flush;
  assign flags_we    = done && req_q.set_flags;
  assign result      = done ? product : result_q;
  assign result_dest = done ? req_q.dest : dest_q;
  assign flags_nz    = done ? nz : nz_q;

endmodule
